// File: rtl/execute_if.sv
// Execute-stage bus: operands and instruction fields in, ALU result, branch condition and flags out.
interface execute_if #(
  parameter int WIDTH = 64
);
  logic [3:0]       icode;
  logic [3:0]       ifun;
  logic [WIDTH-1:0] valA;
  logic [WIDTH-1:0] valB;
  logic [WIDTH-1:0] valC;
  logic [WIDTH-1:0] valE;
  logic             cnd;
  logic             zf;
  logic             sf;
  logic             of;

  modport master (
    output icode, ifun, valA, valB, valC,
    input  valE, cnd, zf, sf, of
  );

  modport slave (
    input  icode, ifun, valA, valB, valC,
    output valE, cnd, zf, sf, of
  );
endinterface

// File: rtl/execute.sv
// Y86-64 sequential execute stage: combinational ALU and condition evaluation,
// plus the clocked ZF/SF/OF condition-code register.
module execute #(
  parameter int WIDTH = 64
) (
  input  logic      clk,
  input  logic      reset,
  execute_if.slave  bus
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {
    F_ADD = 4'h0,
    F_SUB = 4'h1,
    F_AND = 4'h2,
    F_XOR = 4'h3
  } alu_fun_e;

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(8);

  logic [WIDTH-1:0] val_a, val_b, val_c;
  logic [WIDTH-1:0] add_res, sub_res, val_e;
  logic             cc_write, of_next;
  logic             zf_q, sf_q, of_q;
  logic             cnd;

  assign val_a   = bus.valA;
  assign val_b   = bus.valB;
  assign val_c   = bus.valC;
  assign add_res = val_b + val_a;
  assign sub_res = val_b - val_a;

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    val_e    = '0;
    cc_write = 1'b0;
    of_next  = 1'b0;
    case (bus.icode)
      I_RRMOVQ:         val_e = val_a;
      I_IRMOVQ:         val_e = val_c;
      I_RMMOVQ,
      I_MRMOVQ:         val_e = val_b + val_c;
      I_CALL, I_PUSHQ:  val_e = val_b - STACK_STEP;
      I_RET,  I_POPQ:   val_e = val_b + STACK_STEP;
      I_OPQ: begin
        case (bus.ifun)
          F_ADD: begin
            val_e    = add_res;
            of_next  = (val_a[MSB] == val_b[MSB]) && (add_res[MSB] != val_b[MSB]);
            cc_write = 1'b1;
          end
          F_SUB: begin
            val_e    = sub_res;
            of_next  = (val_a[MSB] != val_b[MSB]) && (sub_res[MSB] != val_b[MSB]);
            cc_write = 1'b1;
          end
          F_AND: begin
            val_e    = val_b & val_a;
            cc_write = 1'b1;
          end
          F_XOR: begin
            val_e    = val_b ^ val_a;
            cc_write = 1'b1;
          end
          default: val_e = '0;
        endcase
      end
      default: val_e = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (cc_write) begin
      zf_q <= (val_e == '0);
      sf_q <= val_e[MSB];
      of_q <= of_next;
    end
  end

  // Condition uses the flags already registered, so an OPq only influences the following instruction.
  always_comb begin
    cnd = 1'b0;
    if (bus.icode == I_JXX || bus.icode == I_RRMOVQ) begin
      case (bus.ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (sf_q ^ of_q) | zf_q;
        4'h2:    cnd = sf_q ^ of_q;
        4'h3:    cnd = zf_q;
        4'h4:    cnd = ~zf_q;
        4'h5:    cnd = ~(sf_q ^ of_q);
        4'h6:    cnd = ~(sf_q ^ of_q) & ~zf_q;
        default: cnd = 1'b0;
      endcase
    end
  end

  assign bus.valE = val_e;
  assign bus.cnd  = cnd;
  assign bus.zf   = zf_q;
  assign bus.sf   = sf_q;
  assign bus.of   = of_q;

endmodule

// File: tb/tb_execute.sv
// Directed-vector bench for the execute stage with hand-computed expected values.
module tb_execute;

  localparam int WIDTH = 64;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  execute_if #(.WIDTH(WIDTH)) bus ();

  execute #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    bus.icode = ic;
    bus.ifun  = fn;
    bus.valA  = a;
    bus.valB  = b;
    bus.valC  = c;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cc(input string tag, input logic z, input logic s, input logic o);
    check({tag, ".zf"}, 64'(bus.zf), 64'(z));
    check({tag, ".sf"}, 64'(bus.sf), 64'(s));
    check({tag, ".of"}, 64'(bus.of), 64'(o));
  endtask

  initial begin
    reset = 1'b1;
    drive(4'h1, 4'h0, '0, '0, '0);
    step();
    reset = 1'b0;

    // Reset state and je taken
    drive(4'h7, 4'h3, '0, '0, '0);
    check_cc("reset", 1'b1, 1'b0, 1'b0);
    check("reset.je", 64'(bus.cnd), 64'd1);

    // Add with overflow; flags change only after the edge
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, '0);
    check("add.valE", bus.valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check_cc("add.pre", 1'b1, 1'b0, 1'b0);
    step();
    check_cc("add.post", 1'b0, 1'b1, 1'b1);
    drive(4'h7, 4'h2, '0, '0, '0);
    check("add.jl", 64'(bus.cnd), 64'd0);
    drive(4'h7, 4'h5, '0, '0, '0);
    check("add.jge", 64'(bus.cnd), 64'd1);
    drive(4'h7, 4'h6, '0, '0, '0);
    check("add.jg", 64'(bus.cnd), 64'd1);

    // Stack / memory addressing, no CC change
    drive(4'hA, 4'h0, '0, 64'h100, '0);
    check("pushq.valE", bus.valE, 64'hF8);
    step();
    drive(4'h9, 4'h0, '0, 64'hF8, '0);
    check("ret.valE", bus.valE, 64'h100);
    step();
    drive(4'h4, 4'h0, '0, 64'd16, 64'd8);
    check("rmmovq.valE", bus.valE, 64'd24);
    step();
    check_cc("addr.hold", 1'b0, 1'b1, 1'b1);
    drive(4'h3, 4'h0, 64'h11, 64'h22, 64'hDEAD_BEEF);
    check("irmovq.valE", bus.valE, 64'hDEAD_BEEF);
    check("irmovq.cnd", 64'(bus.cnd), 64'd0);

    // Sub to zero, then cmovne not taken
    drive(4'h6, 4'h1, 64'd5, 64'd5, '0);
    check("sub0.valE", bus.valE, 64'd0);
    step();
    check_cc("sub0", 1'b1, 1'b0, 1'b0);
    drive(4'h2, 4'h4, 64'h123, 64'h456, '0);
    check("cmovne.cnd", 64'(bus.cnd), 64'd0);
    check("cmovne.valE", bus.valE, 64'h123);
    drive(4'h7, 4'h1, '0, '0, '0);
    check("sub0.jle", 64'(bus.cnd), 64'd1);
    drive(4'h7, 4'h7, '0, '0, '0);
    check("jxx.ifun7", 64'(bus.cnd), 64'd0);

    // Wrap on call/pushq
    drive(4'h8, 4'h0, '0, 64'd0, '0);
    check("call.wrap", bus.valE, 64'hFFFF_FFFF_FFFF_FFF8);

    // Sub with overflow: min - 1
    drive(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, '0);
    check("subov.valE", bus.valE, 64'h7FFF_FFFF_FFFF_FFFF);
    step();
    check_cc("subov", 1'b0, 1'b0, 1'b1);
    drive(4'h7, 4'h2, '0, '0, '0);
    check("subov.jl", 64'(bus.cnd), 64'd1);

    // And then xor to zero
    drive(4'h6, 4'h2, 64'hF0F0, 64'hFF00_0000_0000_FF00, '0);
    check("and.valE", bus.valE, 64'hF000);
    step();
    check_cc("and", 1'b0, 1'b0, 1'b0);
    drive(4'h6, 4'h3, 64'hAA, 64'hAA, '0);
    check("xor.valE", bus.valE, 64'd0);
    step();
    check_cc("xor", 1'b1, 1'b0, 1'b0);

    // Reset beats a simultaneous update
    drive(4'h6, 4'h1, 64'd1, 64'd0, '0);
    check("neg.valE", bus.valE, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check_cc("neg", 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    drive(4'h6, 4'h1, 64'd1, 64'd0, '0);
    check("rst.valE", bus.valE, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    reset = 1'b0;
    check_cc("rst_wins", 1'b1, 1'b0, 1'b0);

    // Invalid OPq function: valE 0, CC held
    drive(4'h6, 4'h1, 64'd1, 64'd0, '0);
    step();
    drive(4'h6, 4'h7, 64'd5, 64'd9, '0);
    check("opq7.valE", bus.valE, 64'd0);
    step();
    check_cc("opq7.hold", 1'b0, 1'b1, 1'b0);
    drive(4'hC, 4'h0, 64'd5, 64'd9, 64'd3);
    check("icodeC.valE", bus.valE, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
